iob_cache_be_mem: RTL

Synchronous IOB responder that terminates the cache back-end master port: it accepts line-refill reads and write-through/write-back writes from the cache back-end and serves them from an internal word-addressed RAM with programmable access latency. It sits on the memory side of the cache's back-end IOB interface and is the standard memory subordinate for cache system tests and small SoCs.

---
 rtl/iob_cache_be_mem_if.sv | 24 ++
 rtl/iob_cache_be_mem.sv | 132 +++++++++++++
 2 files changed

// File: rtl/iob_cache_be_mem_if.sv
// IOB back-end bus between the cache back-end master and the memory responder.
// Signal names keep the responder's point of view (_i into memory, _o out of it).
interface iob_cache_be_mem_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic                  avalid_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [DATA_W/8-1:0]   wstrb_i;
    logic                  ready_o;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     rdata_o;

    modport master (
        output avalid_i, addr_i, wdata_i, wstrb_i,
        input  ready_o, rvalid_o, rdata_o
    );

    modport slave (
        input  avalid_i, addr_i, wdata_i, wstrb_i,
        output ready_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/iob_cache_be_mem.sv
// Word-addressed RAM responder for the cache back-end IOB port with fixed read latency.
// Optional IOB_CACHE_BE_MEM_STALL_EN adds LFSR-driven back-pressure on ready_o.
module iob_cache_be_mem #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 2
) (
    input logic               clk_i,
    input logic               rst_n_i,
    iob_cache_be_mem_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int NB_W  = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     ram [DEPTH];

    logic                  ready;
    logic                  accept;
    logic                  is_rd;
    logic [MEM_ADDR_W-1:0] req_idx;
    logic                  unused_addr;

    // Byte offset and bits above the word index are deliberately dropped: addresses alias.
    assign req_idx     = bus.addr_i[NB_W +: MEM_ADDR_W];
    assign unused_addr = ^bus.addr_i;
    assign is_rd       = (bus.wstrb_i == '0);
    assign accept      = bus.avalid_i & ready;

`ifdef IOB_CACHE_BE_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; bit 0 throttles acceptance in IDLE.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ready = (state_q == ST_IDLE) & lfsr_q[0];
`else
    assign ready = (state_q == ST_IDLE);
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_pend_d = rd_pend_q;
        idx_d     = idx_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        if (is_rd) begin
                            rvalid_d = 1'b1;
                            rdata_d  = ram[req_idx];
                        end
                    end else begin
                        state_d   = ST_BUSY;
                        cnt_d     = CNT_W'(LATENCY - 1);
                        rd_pend_d = is_rd;
                        idx_d     = req_idx;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_IDLE;
                    rd_pend_d = 1'b0;
                    if (rd_pend_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = ram[idx_q];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            idx_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            idx_q     <= idx_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // NOTE: the RAM has no reset branch; contents survive reset and it maps onto plain memory.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && accept && !is_rd) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wstrb_i[i]) begin
                    ram[req_idx][8*i +: 8] <= bus.wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready_o  = ready;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
endmodule
